// File: rtl/mem_pattern_tester_if.sv
// Word-oriented req/ack memory bus between the pattern tester (master) and a
// memory controller (slave).
//   mem_req   : transaction request, held with addr/we/wdata until mem_ack
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_ack   : transaction accepted/completed; mem_rdata valid same cycle
//   mem_rdata : read data
interface mem_pattern_tester_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 22
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_pattern_tester.sv
// Memory soak tester: writes a selectable pattern over [addr_lo, addr_hi],
// reads the window back, compares, and keeps pass / failing-word counters
// plus the details of the first mismatch.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable_i        : run request (sampled in IDLE and PASS_END only)
//   mode_i          : 0 LFSR, 1 address-as-data, 2 walking-one, 3 checkerboard
//   addr_lo_i/hi_i  : inclusive word window, latched at pass start
//   clr_err_i       : clears the first-failure capture
//   mem_if          : req/ack memory bus (master side)
//   passcount_o     : completed passes (wraps)
//   failcount_o     : mismatching words (saturates)
//   err_*_o         : first-mismatch capture (sticky valid, addr, exp, got)
//   cfg_err_o       : one-cycle pulse when a pass is refused (lo > hi)
//   state_o         : FSM state for debug
module mem_pattern_tester #(
  parameter int          DATA_W = 16,
  parameter int          ADDR_W = 22,
  parameter logic [31:0] SEED   = 32'hACE1_0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic [ADDR_W-1:0]    addr_lo_i,
  input  logic [ADDR_W-1:0]    addr_hi_i,
  input  logic                 clr_err_i,
  mem_pattern_tester_if.master mem_if,
  output logic [31:0]          passcount_o,
  output logic [31:0]          failcount_o,
  output logic                 err_valid_o,
  output logic [ADDR_W-1:0]    err_addr_o,
  output logic [DATA_W-1:0]    err_exp_o,
  output logic [DATA_W-1:0]    err_got_o,
  output logic                 cfg_err_o,
  output logic [2:0]           state_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_TURN     = 3'd3;
  localparam logic [2:0] S_READ     = 3'd4;
  localparam logic [2:0] S_PASS_END = 3'd5;

  // Widths wide enough to zero-extend the address for mode 1 and to add
  // address + pass count without overflow for mode 2.
  localparam int XW    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int SUM_W = ((ADDR_W > 32) ? ADDR_W : 32) + 1;

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [31:0]       p_q, p_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       save_q, save_d;
  logic [31:0]       pass_q, pass_d;
  logic [31:0]       fail_q, fail_d;
  logic              errv_q, errv_d;
  logic [ADDR_W-1:0] erra_q, erra_d;
  logic [DATA_W-1:0] erre_q, erre_d;
  logic [DATA_W-1:0] errg_q, errg_d;
  logic              cfg_q, cfg_d;

  logic              req, we;
  logic [31:0]       lfsr_nx;
  logic [DATA_W-1:0] pat;

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] c,
    input logic [31:0]       p,
    input logic [31:0]       l
  );
    logic [DATA_W-1:0] r;
    logic [XW-1:0]     cz;
    logic [SUM_W-1:0]  s;
    r  = '0;
    cz = XW'(c);
    s  = SUM_W'(c) + SUM_W'(p);
    case (m)
      2'd0:    r = l[DATA_W-1:0];
      2'd1:    r = cz[DATA_W-1:0] ^ {DATA_W{p[0]}};
      2'd2:    r = DATA_W'(1) << (s % SUM_W'(DATA_W));
      default: r = {(DATA_W/2){2'b01}} ^ {DATA_W{c[0] ^ p[0]}};
    endcase
    return r;
  endfunction

  // Fibonacci LFSR, shift left, taps 31/21/1/0 fed into bit 0.
  assign lfsr_nx = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign pat     = pattern(mode_q, cur_q, p_q, lfsr_q);

  // Bus outputs decode straight from state so reset drops mem_req at once;
  // addr/data are held because cur/lfsr only move on mem_ack.
  assign req              = (state_q == S_WRITE) || (state_q == S_READ);
  assign we               = (state_q == S_WRITE);
  assign mem_if.mem_req   = req;
  assign mem_if.mem_we    = we;
  assign mem_if.mem_addr  = req ? cur_q : '0;
  assign mem_if.mem_wdata = we ? pat : '0;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cur_d   = cur_q;
    p_d     = p_q;
    lfsr_d  = lfsr_q;
    save_d  = save_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    errv_d  = errv_q;
    erra_d  = erra_q;
    erre_d  = erre_q;
    errg_d  = errg_q;
    cfg_d   = 1'b0;

    if (clr_err_i) begin
      errv_d = 1'b0;
      erra_d = '0;
      erre_d = '0;
      errg_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_START;
      end
      S_START: begin
        mode_d = mode_i;
        lo_d   = addr_lo_i;
        hi_d   = addr_hi_i;
        p_d    = pass_q;
        lfsr_d = SEED ^ pass_q;
        save_d = SEED ^ pass_q;
        if (addr_lo_i > addr_hi_i) begin
          cfg_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cur_d   = addr_lo_i;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_if.mem_ack) begin
          lfsr_d = lfsr_nx;
          if (cur_q == hi_q) state_d = S_TURN;
          else               cur_d   = cur_q + ADDR_W'(1);
        end
      end
      S_TURN: begin
        lfsr_d  = save_q;
        cur_d   = lo_q;
        state_d = S_READ;
      end
      S_READ: begin
        if (mem_if.mem_ack) begin
          lfsr_d = lfsr_nx;
          if (mem_if.mem_rdata != pat) begin
            if (fail_q != '1) fail_d = fail_q + 32'd1;
            // Capture overrides a same-cycle clr_err.
            if (!errv_q) begin
              errv_d = 1'b1;
              erra_d = cur_q;
              erre_d = pat;
              errg_d = mem_if.mem_rdata;
            end
          end
          if (cur_q == hi_q) state_d = S_PASS_END;
          else               cur_d   = cur_q + ADDR_W'(1);
        end
      end
      S_PASS_END: begin
        pass_d  = pass_q + 32'd1;
        state_d = enable_i ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cur_q   <= '0;
      p_q     <= '0;
      lfsr_q  <= SEED;
      save_q  <= SEED;
      pass_q  <= '0;
      fail_q  <= '0;
      errv_q  <= 1'b0;
      erra_q  <= '0;
      erre_q  <= '0;
      errg_q  <= '0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cur_q   <= cur_d;
      p_q     <= p_d;
      lfsr_q  <= lfsr_d;
      save_q  <= save_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      errv_q  <= errv_d;
      erra_q  <= erra_d;
      erre_q  <= erre_d;
      errg_q  <= errg_d;
      cfg_q   <= cfg_d;
    end
  end

  assign passcount_o = pass_q;
  assign failcount_o = fail_q;
  assign err_valid_o = errv_q;
  assign err_addr_o  = erra_q;
  assign err_exp_o   = erre_q;
  assign err_got_o   = errg_q;
  assign cfg_err_o   = cfg_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Bench for mem_pattern_tester: table of expected write transactions for
// several modes/windows, plus directed sequences for LFSR with random ack
// delay, stuck-bit capture, refused passes, mid-write reset and failcount
// saturation.
module tb_mem_pattern_tester;
  localparam int DW = 16;
  localparam int AW = 22;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] addr_lo = '0;
  logic [AW-1:0] addr_hi = '0;
  logic          clr_err = 1'b0;
  logic [31:0]   passcount, failcount;
  logic          err_valid, cfg_err;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp, err_got;
  logic [2:0]    state;

  mem_pattern_tester_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  mem_pattern_tester #(.DATA_W(DW), .ADDR_W(AW), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .mode_i(mode),
    .addr_lo_i(addr_lo), .addr_hi_i(addr_hi), .clr_err_i(clr_err),
    .mem_if(mif), .passcount_o(passcount), .failcount_o(failcount),
    .err_valid_o(err_valid), .err_addr_o(err_addr), .err_exp_o(err_exp),
    .err_got_o(err_got), .cfg_err_o(cfg_err), .state_o(state)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          wlog[$];
  ent_t          rlog[$];
  logic [DW-1:0] memarr [0:255];
  int unsigned   cnt = 0;
  int unsigned   max_dly = 0;
  logic          fault_en = 1'b0;
  logic [AW-1:0] f_lo = '0, f_hi = '0;
  logic          pend = 1'b0;
  logic [AW-1:0] h_a = '0;
  logic [DW-1:0] h_d = '0;
  logic          h_we = 1'b0;
  int            stab_bad = 0;

  assign mif.mem_ack   = mif.mem_req && (cnt == 0);
  assign mif.mem_rdata = memarr[mif.mem_addr[7:0]] |
                         ((fault_en && mif.mem_addr >= f_lo && mif.mem_addr <= f_hi) ? 16'h0008 : 16'h0000);

  always @(posedge clk) begin
    if (pend && mif.mem_req &&
        (mif.mem_addr !== h_a || mif.mem_wdata !== h_d || mif.mem_we !== h_we))
      stab_bad <= stab_bad + 1;
    pend <= mif.mem_req && !mif.mem_ack;
    h_a  <= mif.mem_addr;
    h_d  <= mif.mem_wdata;
    h_we <= mif.mem_we;
    if (mif.mem_req && mif.mem_ack) begin
      if (mif.mem_we) begin
        memarr[mif.mem_addr[7:0]] <= mif.mem_wdata;
        wlog.push_back('{mif.mem_addr, mif.mem_wdata});
      end else begin
        rlog.push_back('{mif.mem_addr, mif.mem_rdata});
      end
      cnt <= $urandom_range(max_dly);
    end else if (mif.mem_req && cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wlog.delete();
    rlog.delete();
    @(negedge clk);
  endtask

  // Hold enable until the n-th pass reaches PASS_END, then let it go idle.
  task automatic run_passes(input int n, input string nm);
    logic [31:0] start;
    bit done;
    start  = passcount;
    done   = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (state == 3'd5 && passcount == start + 32'(n - 1)) enable = 1'b0;
      if (!enable && state == 3'd0) done = 1'b1;
    end
    enable = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL %s: timeout, state %0d passcount %0d", nm, state, passcount);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] lo, hi;
    int            idx;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [0:NV-1];

  initial begin
    logic [31:0] l;
    int st, cf, rq;
    bit found;

    // Two passes per window; pass 1 uses p = 1.
    vecs[0]  = '{2'd1, 22'd0,  22'd3,  0, 22'd0,  16'h0000};
    vecs[1]  = '{2'd1, 22'd0,  22'd3,  1, 22'd1,  16'h0001};
    vecs[2]  = '{2'd1, 22'd0,  22'd3,  2, 22'd2,  16'h0002};
    vecs[3]  = '{2'd1, 22'd0,  22'd3,  3, 22'd3,  16'h0003};
    vecs[4]  = '{2'd1, 22'd0,  22'd3,  4, 22'd0,  16'hFFFF};
    vecs[5]  = '{2'd1, 22'd0,  22'd3,  5, 22'd1,  16'hFFFE};
    vecs[6]  = '{2'd1, 22'd0,  22'd3,  6, 22'd2,  16'hFFFD};
    vecs[7]  = '{2'd1, 22'd0,  22'd3,  7, 22'd3,  16'hFFFC};
    vecs[8]  = '{2'd2, 22'd14, 22'd17, 0, 22'd14, 16'h4000};
    vecs[9]  = '{2'd2, 22'd14, 22'd17, 1, 22'd15, 16'h8000};
    vecs[10] = '{2'd2, 22'd14, 22'd17, 2, 22'd16, 16'h0001};
    vecs[11] = '{2'd2, 22'd14, 22'd17, 3, 22'd17, 16'h0002};
    vecs[12] = '{2'd2, 22'd14, 22'd17, 4, 22'd14, 16'h8000};
    vecs[13] = '{2'd2, 22'd14, 22'd17, 5, 22'd15, 16'h0001};
    vecs[14] = '{2'd2, 22'd14, 22'd17, 7, 22'd17, 16'h0004};
    vecs[15] = '{2'd3, 22'd2,  22'd3,  0, 22'd2,  16'h5555};
    vecs[16] = '{2'd3, 22'd2,  22'd3,  1, 22'd3,  16'hAAAA};
    vecs[17] = '{2'd3, 22'd2,  22'd3,  2, 22'd2,  16'hAAAA};
    vecs[18] = '{2'd3, 22'd2,  22'd3,  3, 22'd3,  16'h5555};
    vecs[19] = '{2'd1, 22'd5,  22'd5,  0, 22'd5,  16'h0005};
    vecs[20] = '{2'd1, 22'd5,  22'd5,  1, 22'd5,  16'hFFFA};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", mif.mem_req, 1'b0);
    chk("rst_mem_bus", {mif.mem_we, mif.mem_addr, mif.mem_wdata}, '0);
    chk("rst_counts", {passcount, failcount}, '0);
    chk("rst_err", {err_valid, err_addr, err_exp, err_got, cfg_err}, '0);
    chk("rst_state", state, 3'd0);
    rst_n = 1'b1;

    // Table: zero-wait, two passes per window
    max_dly = 0;
    for (int i = 0; i < NV; i++) begin
      if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].lo != vecs[i-1].lo ||
          vecs[i].hi != vecs[i-1].hi) begin
        do_reset();
        mode    = vecs[i].mode;
        addr_lo = vecs[i].lo;
        addr_hi = vecs[i].hi;
        run_passes(2, "tbl_run");
        chk("tbl_passcount", passcount, 32'd2);
        chk("tbl_failcount", failcount, 32'd0);
        chk("tbl_err_valid", err_valid, 1'b0);
        chk("tbl_nwrites", wlog.size(), 2 * (vecs[i].hi - vecs[i].lo + 1));
      end
      if (vecs[i].idx < wlog.size()) begin
        chk("tbl_waddr", wlog[vecs[i].idx].a, vecs[i].e_addr);
        chk("tbl_wdata", wlog[vecs[i].idx].d, vecs[i].e_data);
      end else begin
        n_chk++;
        $display("FAIL tbl_missing: write %0d absent, got %0d writes", vecs[i].idx, wlog.size());
      end
    end

    // LFSR mode with random 0-3 cycle ack delay
    do_reset();
    max_dly = 3;
    mode = 2'd0; addr_lo = 22'h10; addr_hi = 22'h1F;
    stab_bad = 0;
    run_passes(1, "lfsr_run");
    chk("lfsr_nwrites", wlog.size(), 16);
    chk("lfsr_nreads", rlog.size(), 16);
    l = SEED;
    for (int i = 0; i < 16 && i < wlog.size() && i < rlog.size(); i++) begin
      chk("lfsr_waddr", wlog[i].a, 22'h10 + 22'(i));
      chk("lfsr_wdata", wlog[i].d, l[15:0]);
      chk("lfsr_raddr", rlog[i].a, 22'h10 + 22'(i));
      chk("lfsr_rdata", rlog[i].d, l[15:0]);
      l = lfsr_step(l);
    end
    chk("lfsr_failcount", failcount, 32'd0);
    chk("lfsr_stable", stab_bad, 0);
    max_dly = 0;

    // Stuck bit 3 at address 5, walking-one
    do_reset();
    fault_en = 1'b1; f_lo = 22'd5; f_hi = 22'd5;
    mode = 2'd2; addr_lo = 22'd0; addr_hi = 22'd7;
    run_passes(1, "stuck_run1");
    chk("stuck_fail1", failcount, 32'd1);
    chk("stuck_errv1", err_valid, 1'b1);
    chk("stuck_addr1", err_addr, 22'd5);
    chk("stuck_exp1", err_exp, 16'h0020);
    chk("stuck_got1", err_got, 16'h0028);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_errv", err_valid, 1'b0);
    chk("clr_fields", {err_addr, err_exp, err_got}, '0);
    run_passes(1, "stuck_run2");
    chk("stuck_fail2", failcount, 32'd2);
    chk("stuck_errv2", err_valid, 1'b1);
    chk("stuck_addr2", err_addr, 22'd5);
    chk("stuck_exp2", err_exp, 16'h0040);
    chk("stuck_got2", err_got, 16'h0048);
    fault_en = 1'b0;

    // Reset in the middle of WRITE (counters nonzero beforehand)
    mode = 2'd1; addr_lo = 22'h20; addr_hi = 22'h27;
    enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (state == 3'd2 && mif.mem_addr == 22'h22) found = 1'b1;
    end
    chk("midrst_reached", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", mif.mem_req, 1'b0);
    chk("midrst_state", state, 3'd0);
    chk("midrst_counts", {passcount, failcount}, '0);
    chk("midrst_errv", err_valid, 1'b0);
    @(negedge clk);
    wlog.delete();
    rlog.delete();
    rst_n = 1'b1;
    run_passes(1, "midrst_run");
    chk("midrst_nwrites", wlog.size(), 8);
    if (wlog.size() > 0) begin
      chk("midrst_first_addr", wlog[0].a, 22'h20);
      chk("midrst_first_data", wlog[0].d, 16'h0020);
    end
    chk("midrst_passcount", passcount, 32'd1);

    // Refused pass: lo > hi
    do_reset();
    addr_lo = 22'd8; addr_hi = 22'd4;
    st = 0; cf = 0; rq = 0;
    enable = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 19) enable = 1'b0;
      if (state == 3'd1) st++;
      if (cfg_err) cf++;
      if (mif.mem_req) rq++;
    end
    chk("cfg_starts_seen", st > 0, 1'b1);
    chk("cfg_pulses", cf, st);
    chk("cfg_no_req", rq, 0);
    chk("cfg_passcount", passcount, 32'd0);
    chk("cfg_state", state, 3'd0);

    // failcount saturation
    do_reset();
    force dut.fail_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.fail_q;
    @(negedge clk);
    chk("sat_preload", failcount, 32'hFFFF_FFFE);
    fault_en = 1'b1; f_lo = 22'd0; f_hi = 22'd2;
    mode = 2'd2; addr_lo = 22'd0; addr_hi = 22'd7;
    run_passes(1, "sat_run");
    chk("sat_failcount", failcount, 32'hFFFF_FFFF);
    chk("sat_err_addr", err_addr, 22'd0);
    chk("sat_err_exp", err_exp, 16'h0001);
    chk("sat_err_got", err_got, 16'h0009);
    fault_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_pattern_tester.md
Name: mem_pattern_tester

Overview:
Parametrised memory soak tester. It repeatedly writes a selectable test pattern over a programmable address window, reads the window back and compares, then counts passes and failing words. It talks to the memory controller over a generic req/ack word interface, so the same block drives SDRAM, SRAM or BRAM controllers. It also keeps the first-failure details for debug readout.

Parameters:
DATA_W, 16, data word width; even, 8..32
ADDR_W, 22, word address width
SEED, 32'hACE1_0001, LFSR base seed; must be non-zero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; sampled only in IDLE and at pass end
mode  in  2  0=LFSR, 1=address-as-data, 2=walking-one, 3=checkerboard; latched at pass start
addr_lo  in  ADDR_W  first word address, inclusive; latched at pass start
addr_hi  in  ADDR_W  last word address, inclusive; latched at pass start
clr_err  in  1  clears err_valid, err_addr, err_exp, err_got
mem_req  out  1  transaction request
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  transaction accepted/completed; read data valid in the same cycle
mem_rdata  in  DATA_W  read data
passcount  out  32  completed passes; wraps
failcount  out  32  mismatching words; saturates at 32'hFFFF_FFFF
err_valid  out  1  sticky; first mismatch captured
err_addr  out  ADDR_W  address of first mismatch
err_exp  out  DATA_W  expected data at first mismatch
err_got  out  DATA_W  read data at first mismatch
cfg_err  out  1  one-cycle pulse when a pass is refused
state  out  3  FSM state for debug

Behaviour:
- Reset: every output is 0, FSM is in IDLE, LFSR is loaded with SEED. Asserting reset mid-transaction drops mem_req immediately.
- States: IDLE=0, START=1, WRITE=2, TURN=3, READ=4, PASS_END=5.
- IDLE: when enable=1, go to START.
- START:
  - Latch mode, addr_lo and addr_hi. Load the LFSR with SEED ^ passcount and save a copy of that value.
  - If addr_lo > addr_hi: pulse cfg_err and return to IDLE. No memory access occurs.
  - Otherwise set cur = addr_lo and go to WRITE.
- WRITE:
  - Drive mem_req=1, mem_we=1, mem_addr=cur and mem_wdata=pattern(cur).
  - Hold all of them stable until mem_ack.
  - On mem_ack: advance the LFSR. If cur == addr_hi, go to TURN; else cur+1 and mem_req stays 1 (back-to-back is allowed).
- TURN: mem_req=0 for one cycle. Restore the saved LFSR value, set cur = addr_lo, go to READ.
- READ:
  - Drive mem_req=1, mem_we=0 and mem_addr=cur.
  - On mem_ack, compare mem_rdata with pattern(cur) and advance the LFSR.
  - On mismatch: failcount+1 (saturating). If err_valid=0, capture err_addr, err_exp and err_got and set err_valid.
  - If cur == addr_hi, go to PASS_END; else cur+1.
- PASS_END: passcount+1. If enable=1 go to START, else go to IDLE. enable is ignored mid-pass, so a pass always completes.
- Patterns, with p = passcount value latched at START:
  - mode 0: LFSR[DATA_W-1:0]. The LFSR is 32-bit Fibonacci, shifts left, feedback = b31^b21^b1^b0 into b0.
  - mode 1: {cur zero-extended or truncated to DATA_W} XOR {DATA_W{p[0]}}.
  - mode 2: one-hot, bit index (cur + p) mod DATA_W.
  - mode 3: {DATA_W/2{2'b01}} XOR {DATA_W{cur[0]^p[0]}}.
- Address increments use ADDR_W width. addr_hi = all-ones terminates by equality and never wraps.
- clr_err and a simultaneous capture in the same cycle: the capture wins.
- mem_ack outside WRITE/READ, or while mem_req=0, is ignored.

Test Plan:
- Zero-wait model (mem_ack=mem_req), mode=1, addr_lo=0, addr_hi=3, enable held for 2 passes:
  - pass 0 writes 0,1,2,3; pass 1 writes FFFF,FFFE,FFFD,FFFC;
  - passcount=2, failcount=0, err_valid=0.
- Mode 0, window 0x10..0x1F, model with random 0-3 cycle ack delay -> read sequence matches write sequence, failcount=0, and mem_addr/mem_wdata stay stable while mem_req=1 && !mem_ack.
- Model forces bit 3 stuck-1 at address 5, mode 3, window 0..7:
  - failcount=1 per pass (word 5 expected 0x5555^0xFFFF=0xAAAA has bit3=1, so choose mode 2, where address 5 expects 0x0020 and returns 0x0028);
  - err_addr=5, err_exp=0x0020, err_got=0x0028;
  - after clr_err, err_valid=0 and it re-captures on the next pass.
- addr_lo=8, addr_hi=4, enable=1 -> cfg_err pulses once per START attempt, mem_req never asserted, passcount=0.
- Assert rst_n=0 in the middle of WRITE -> mem_req=0 asynchronously, all counters=0, state=0. After release with enable=1, the next pass starts from addr_lo.
- failcount preloaded via force to 32'hFFFF_FFFE, 3 mismatches -> failcount=32'hFFFF_FFFF.
